// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types for the router dispatch block
package router_pkg;
  localparam int ROUTER_PORTS = 4;

  typedef logic [1:0] port_addr_t;
  typedef logic [3:0] credit_cnt_t;
endpackage

// File: rtl/router_sync_fifo.sv
// rtl/router_sync_fifo.sv - synchronous FIFO, head visible on rdata_o, separate occupancy count
module router_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/router_dispatch.sv
// rtl/router_dispatch.sv - credit-gated in-order feeder for the 4-port router
// Optional ROUTER_DISPATCH_STATS_EN adds stat_sent / stat_stall counters.
module router_dispatch
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic [1:0]                      s_addr,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [DATA_WIDTH-1:0]           din,
  output logic                            d_en,
  output logic [1:0]                      addr,
  input  logic [3:0]                      credit_ret,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            stall,
  output logic [3:0]                      credit_err
`ifdef ROUTER_DISPATCH_STATS_EN
  ,
  output logic [63:0]                     stat_sent,
  output logic [15:0]                     stat_stall
`endif
);
  localparam int          EW         = DATA_WIDTH + 2;
  localparam credit_cnt_t CREDIT_MAX = credit_cnt_t'(CREDITS);

  logic [EW-1:0]           head;
  logic [DATA_WIDTH-1:0]   head_data;
  port_addr_t              head_addr;
  logic                    fifo_full, fifo_empty, push, pop;
  logic [ROUTER_PORTS-1:0] disp_vec;

  credit_cnt_t             credit_q [ROUTER_PORTS];
  credit_cnt_t             credit_d [ROUTER_PORTS];
  logic [3:0]              credit_err_q, credit_err_d;
  logic                    d_en_q, d_en_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  port_addr_t              addr_q, addr_d;

  router_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i ({s_data, s_addr}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_level)
  );

  assign head_addr = head[1:0];
  assign head_data = head[EW-1:2];
  assign s_ready   = !fifo_full;
  assign push      = s_valid && s_ready;
  assign pop       = !fifo_empty && (credit_q[head_addr] != '0);
  assign stall     = !fifo_empty && (credit_q[head_addr] == '0);
  assign disp_vec  = pop ? (ROUTER_PORTS'(1) << head_addr) : '0;

  always_comb begin
    credit_err_d = credit_err_q;
    d_en_d       = pop;
    din_d        = pop ? head_data : '0;
    addr_d       = pop ? head_addr : '0;
    for (int i = 0; i < ROUTER_PORTS; i++) begin
      credit_d[i] = credit_q[i];
      // A return that coincides with a dispatch to the same port cancels out.
      if (credit_ret[i] && !disp_vec[i]) begin
        if (credit_q[i] == CREDIT_MAX) credit_err_d[i] = 1'b1;
        else                           credit_d[i] = credit_q[i] + credit_cnt_t'(1);
      end else if (disp_vec[i] && !credit_ret[i]) begin
        credit_d[i] = credit_q[i] - credit_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROUTER_PORTS; i++) credit_q[i] <= CREDIT_MAX;
      credit_err_q <= '0;
      d_en_q       <= 1'b0;
      din_q        <= '0;
      addr_q       <= '0;
    end else begin
      for (int i = 0; i < ROUTER_PORTS; i++) credit_q[i] <= credit_d[i];
      credit_err_q <= credit_err_d;
      d_en_q       <= d_en_d;
      din_q        <= din_d;
      addr_q       <= addr_d;
    end
  end

  assign d_en       = d_en_q;
  assign din        = din_q;
  assign addr       = addr_q;
  assign credit_err = credit_err_q;

`ifdef ROUTER_DISPATCH_STATS_EN
  logic [15:0] sent_q [ROUTER_PORTS];
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROUTER_PORTS; i++) sent_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ROUTER_PORTS; i++) begin
        if (disp_vec[i]) sent_q[i] <= sent_q[i] + 16'd1;
      end
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_sent  = {sent_q[3], sent_q[2], sent_q[1], sent_q[0]};
  assign stat_stall = stall_cnt_q;
`endif
endmodule

// File: tb/tb_router_dispatch.sv
// tb/tb_router_dispatch.sv - scoreboard bench for router_dispatch
module tb_router_dispatch;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_data;
  logic [1:0]  s_addr;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] din;
  logic        d_en;
  logic [1:0]  addr;
  logic [3:0]  credit_ret;
  logic [2:0]  fifo_level;
  logic        stall;
  logic [3:0]  credit_err;
`ifdef ROUTER_DISPATCH_STATS_EN
  logic [63:0] stat_sent;
  logic [15:0] stat_stall;
`endif

  always #5 clk = ~clk;

  router_dispatch #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CREDITS(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_data     (s_data),
    .s_addr     (s_addr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .din        (din),
    .d_en       (d_en),
    .addr       (addr),
    .credit_ret (credit_ret),
    .fifo_level (fifo_level),
    .stall      (stall),
    .credit_err (credit_err)
`ifdef ROUTER_DISPATCH_STATS_EN
    ,
    .stat_sent  (stat_sent),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct packed {
    logic [1:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sent_seen[4];
  int   stall_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (stall) stall_seen++;
      if (d_en) begin
        if (sb.size() == 0) check("unexpected_dispatch", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("dispatch_addr", addr, mon_e.a);
          check("dispatch_data", din, mon_e.d);
          sent_seen[addr]++;
        end
      end else begin
        check("idle_outputs_zero", {addr, din}, 0);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [1:0] pa, input logic [31:0] pd);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_addr  = pa;
    s_data  = pd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        sb.push_back('{a: pa, d: pd});
        #1;
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic pulse_ret(input logic [3:0] m);
    credit_ret = m;
    @(posedge clk);
    #1;
    credit_ret = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (fifo_level == 0 && sb.size() == 0) break;
    end
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sync();
  endtask

`ifdef ROUTER_DISPATCH_STATS_EN
  task automatic check_stats(input string tag);
    @(negedge clk);
    #1;
    for (int p = 0; p < 4; p++) check({tag, "_sent"}, stat_sent[p*16 +: 16], 16'(sent_seen[p]));
    check({tag, "_stall"}, stat_stall, 16'(stall_seen));
    sync();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_addr = '0; credit_ret = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_d_en", d_en, 0);
    check("rst_din", din, 0);
    check("rst_level", fifo_level, 0);
    check("rst_stall", stall, 0);
    check("rst_credit_err", credit_err, 0);
    sync();
    resetn = 1'b1;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);
    check("rel_d_en", d_en, 0);
    sync();

    // single word latency
    push_word(2'd2, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_no_bypass", d_en, 0);
    check("t2_level", fifo_level, 1);
    @(negedge clk);
    check("t2_d_en", d_en, 1);
    check("t2_addr", addr, 2);
    @(negedge clk);
    check("t2_one_cycle", d_en, 0);
    sync();

    // credit exhaustion on port 1
    push_word(2'd1, 32'h11111111);
    push_word(2'd1, 32'h22222222);
    push_word(2'd1, 32'h33333333);
    @(negedge clk);
    check("t3_back_to_back", d_en, 1);
    check("t3_stall", stall, 1);
    check("t3_level", fifo_level, 1);
    @(negedge clk);
    check("t3_held", d_en, 0);
    check("t3_stall_hold", stall, 1);
    sync();
    pulse_ret(4'b0010);
    @(negedge clk);
    check("t3_stall_clear", stall, 0);
    check("t3_not_yet", d_en, 0);
    @(negedge clk);
    check("t3_third", d_en, 1);
    check("t3_level0", fifo_level, 0);
    sync();
`ifdef ROUTER_DISPATCH_STATS_EN
    check_stats("t3_stats");
`endif

    // head-of-line blocking
    push_word(2'd1, 32'h44444444);
    push_word(2'd0, 32'h55555555);
    repeat (3) begin
      @(negedge clk);
      check("t4_blocked", d_en, 0);
      check("t4_stall", stall, 1);
      check("t4_level", fifo_level, 2);
    end
    sync();
    pulse_ret(4'b0010);
    @(negedge clk);
    @(negedge clk);
    check("t4_first_port1", {d_en, addr}, {1'b1, 2'd1});
    @(negedge clk);
    check("t4_then_port0", {d_en, addr}, {1'b1, 2'd0});
    sync();

    // credit return onto a full counter
    pulse_ret(4'b1000);
    @(negedge clk);
    check("t6_err_set", credit_err, 4'b1000);
    sync();
    push_word(2'd3, 32'h30000001);
    push_word(2'd3, 32'h30000002);
    push_word(2'd3, 32'h30000003);
    @(negedge clk);
    check("t6_count_held_at_max", stall, 1);
    sync();
    pulse_ret(4'b1000);
    push_word(2'd0, 32'h00000AAA);
    push_word(2'd2, 32'h00000BBB);
    wait_drain("t6_drain");
    check("t6_err_sticky", credit_err, 4'b1000);

    // fill with every credit exhausted
    for (int i = 0; i < 4; i++) push_word(2'd1, 32'hF0000000 + i);
    @(negedge clk);
    check("t5_full_ready", s_ready, 0);
    check("t5_full_level", fifo_level, 4);
    check("t5_full_stall", stall, 1);
    s_valid = 1'b1; s_addr = 2'd1; s_data = 32'hF0000004;
    repeat (3) begin
      @(negedge clk);
      check("t5_held_ready", s_ready, 0);
      check("t5_held_level", fifo_level, 4);
    end
    sync();
    pulse_ret(4'b0010);
    @(negedge clk);
    check("t5_pre_pop_level", fifo_level, 4);
    check("t5_pre_pop_ready", s_ready, 0);
    @(negedge clk);
    check("t5_no_push_on_pop", fifo_level, 3);
    check("t5_ready_again", s_ready, 1);
    @(posedge clk);
    sb.push_back('{a: 2'd1, d: 32'hF0000004});
    #1;
    s_valid = 1'b0;
    repeat (4) pulse_ret(4'b0010);
    wait_drain("t5_drain");
`ifdef ROUTER_DISPATCH_STATS_EN
    check_stats("t5_stats");
`endif

    // reset in the middle of traffic
    pulse_ret(4'b0001);
    push_word(2'd0, 32'hA0A0A0A0);
    push_word(2'd0, 32'hA1A1A1A1);
    @(negedge clk);
    check("rm_d_en_before", d_en, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("rm_d_en_drop", d_en, 0);
    check("rm_level", fifo_level, 0);
    check("rm_credit_err", credit_err, 0);
    check("rm_stall", stall, 0);
`ifdef ROUTER_DISPATCH_STATS_EN
    check("rm_stat_sent", stat_sent, 0);
    check("rm_stat_stall", stat_stall, 0);
`endif
    sb.delete();
    stall_seen = 0;
    for (int p = 0; p < 4; p++) sent_seen[p] = 0;
    sync();
    resetn = 1'b1;
    push_word(2'd3, 32'hC0000001);
    push_word(2'd3, 32'hC0000002);
    wait_drain("rm_credits_restored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
